// File: rtl/vga_pixel_fetch.sv
// Prefetches RGB565 pixels from frame memory into a credit-managed FIFO and
// hands one expanded 24-bit pixel per request to the VGA timing stage.
module vga_pixel_fetch #(
    parameter int                H_ACT      = 640,
    parameter int                V_ACT      = 480,
    parameter int                ADDR_W     = 20,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = {ADDR_W{1'b0}},
    parameter int                FIFO_DEPTH = 16
) (
    input  logic              i_clk_25M,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    input  logic              i_pix_req,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_ready,
    input  logic              i_rd_valid,
    input  logic [15:0]       i_rd_data,
    output logic [7:0]        o_VGA_R,
    output logic [7:0]        o_VGA_G,
    output logic [7:0]        o_VGA_B,
    output logic              o_underflow,
    output logic              o_frame_done
);
    localparam int TOTAL  = H_ACT * V_ACT;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
    localparam int DISC_W = CRED_W + 1;
    localparam logic [CNT_W-1:0]  LAST_ISSUE = CNT_W'(TOTAL - 1);
    localparam logic [CRED_W:0]   DEPTH_C    = (CRED_W + 1)'(FIFO_DEPTH);
    localparam logic [CRED_W-1:0] FULL_C     = CRED_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  issue_q, issue_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_req_q, rd_req_d;
    logic [CRED_W-1:0] out_q, out_d;
    logic [DISC_W-1:0] disc_q, disc_d;
    logic [CRED_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
    logic              underflow_q, underflow_d;
    logic              done_q, done_d;
    logic [15:0]       mem_q [FIFO_DEPTH];

    logic              accept_s, stale_s, push_s, pop_s, empty_s, full_s;
    logic [15:0]       pop_data_s;
    logic [DISC_W-1:0] inflight_s;

    assign accept_s   = rd_req_q & i_rd_ready;
    assign stale_s    = i_rd_valid & (disc_q != {DISC_W{1'b0}});
    assign push_s     = i_rd_valid & (disc_q == {DISC_W{1'b0}}) & ~i_frame_start;
    assign empty_s    = (cnt_q == {CRED_W{1'b0}});
    assign full_s     = (cnt_q == FULL_C);
    // An empty FIFO with a same-cycle return serves the returning word directly.
    assign pop_s      = i_pix_req & ~i_frame_start & (~empty_s | push_s);
    assign pop_data_s = empty_s ? i_rd_data : mem_q[rd_ptr_q];
    // Every word still owed by memory when a new frame starts belongs to the old frame.
    assign inflight_s = disc_q + DISC_W'(out_q) + DISC_W'(accept_s);

    // Next-state logic: frame control, issue/credit tracking, FIFO and pixel output.
    always_comb begin
        state_d     = state_q;
        issue_d     = issue_q;
        addr_d      = addr_q;
        out_d       = out_q;
        disc_d      = disc_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        r_d         = r_q;
        g_d         = g_q;
        b_d         = b_q;
        underflow_d = underflow_q;
        done_d      = done_q;
        if (i_frame_start) begin
            state_d     = S_FETCH;
            issue_d     = {CNT_W{1'b0}};
            addr_d      = BASE_ADDR;
            out_d       = {CRED_W{1'b0}};
            cnt_d       = {CRED_W{1'b0}};
            wr_ptr_d    = {PTR_W{1'b0}};
            rd_ptr_d    = {PTR_W{1'b0}};
            underflow_d = 1'b0;
            done_d      = 1'b0;
            if (i_rd_valid && (inflight_s != {DISC_W{1'b0}})) begin
                disc_d = inflight_s - DISC_W'(1'b1);
            end else begin
                disc_d = inflight_s;
            end
        end else begin
            if (accept_s) begin
                addr_d  = addr_q + ADDR_W'(1'b1);
                issue_d = issue_q + CNT_W'(1'b1);
                if (issue_q == LAST_ISSUE) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end else begin
                addr_d = addr_q;
            end
            if (stale_s) begin
                disc_d = disc_q - DISC_W'(1'b1);
            end else begin
                disc_d = disc_q;
            end
            out_d    = out_q + CRED_W'(accept_s) - CRED_W'(push_s);
            cnt_d    = cnt_q + CRED_W'(push_s) - CRED_W'(pop_s);
            wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
            if (pop_s) begin
                r_d = {pop_data_s[15:11], pop_data_s[15:13]};
                g_d = {pop_data_s[10:5], pop_data_s[10:9]};
                b_d = {pop_data_s[4:0], pop_data_s[4:2]};
            end else if (i_pix_req) begin
                r_d         = 8'h00;
                g_d         = 8'h00;
                b_d         = 8'h00;
                underflow_d = 1'b1;
            end else begin
                underflow_d = underflow_q;
            end
        end
        rd_req_d = (state_d == S_FETCH) &&
                   (((CRED_W + 1)'(cnt_d) + (CRED_W + 1)'(out_d)) < DEPTH_C);
    end

    // State and output registers.
    always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            issue_q     <= {CNT_W{1'b0}};
            addr_q      <= BASE_ADDR;
            rd_req_q    <= 1'b0;
            out_q       <= {CRED_W{1'b0}};
            disc_q      <= {DISC_W{1'b0}};
            cnt_q       <= {CRED_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            r_q         <= 8'h00;
            g_q         <= 8'h00;
            b_q         <= 8'h00;
            underflow_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_q     <= issue_d;
            addr_q      <= addr_d;
            rd_req_q    <= rd_req_d;
            out_q       <= out_d;
            disc_q      <= disc_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            underflow_q <= underflow_d;
            done_q      <= done_d;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge i_clk_25M) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= i_rd_data;
        end
    end

    vga_pixel_fetch_chk u_chk (
        .i_clk   (i_clk_25M),
        .i_rst_n (i_rst_n),
        .i_push  (push_s),
        .i_pop   (pop_s),
        .i_full  (full_s)
    );

    assign o_rd_req     = rd_req_q;
    assign o_rd_addr    = addr_q;
    assign o_VGA_R      = r_q;
    assign o_VGA_G      = g_q;
    assign o_VGA_B      = b_q;
    assign o_underflow  = underflow_q;
    assign o_frame_done = done_q;
endmodule

// Invariant checks for the prefetch FIFO.
module vga_pixel_fetch_chk (
    input logic i_clk,
    input logic i_rst_n,
    input logic i_push,
    input logic i_pop,
    input logic i_full
);
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && i_full && !i_pop));
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: a 4x2 frame instance with a latency-
// programmable memory model, plus an 8x4 instance for the credit limit.
module tb_vga_pixel_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0, pix_req = 1'b0, rd_ready = 1'b0;
    logic        rd_valid = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        rd_req, underflow, frame_done;
    logic [19:0] rd_addr;
    logic [7:0]  vga_r, vga_g, vga_b;

    logic        frame_start2 = 1'b0, rd_ready2 = 1'b0, rd_valid2 = 1'b0;
    logic [15:0] rd_data2 = 16'h0000;
    logic        rd_req2, underflow2, frame_done2;
    logic [19:0] rd_addr2;
    logic [7:0]  vga_r2, vga_g2, vga_b2;

    int total = 0, bad = 0, cyc = 0, lat = 2, mode = 0, acc2 = 0;
    logic [19:0] acc_log[$];
    logic [15:0] dq[$], dq2[$];
    int          due[$], due2[$];

    typedef struct {
        logic [15:0] word;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } pix_vec_t;
    pix_vec_t basic_tbl[8];
    pix_vec_t colour_tbl[6];

    always #5 clk = ~clk;

    vga_pixel_fetch #(.H_ACT(4), .V_ACT(2), .ADDR_W(20), .BASE_ADDR(20'h00100), .FIFO_DEPTH(16)) dut (
        .i_clk_25M(clk), .i_rst_n(rst_n), .i_frame_start(frame_start), .i_pix_req(pix_req),
        .o_rd_req(rd_req), .o_rd_addr(rd_addr), .i_rd_ready(rd_ready), .i_rd_valid(rd_valid),
        .i_rd_data(rd_data), .o_VGA_R(vga_r), .o_VGA_G(vga_g), .o_VGA_B(vga_b),
        .o_underflow(underflow), .o_frame_done(frame_done));

    vga_pixel_fetch #(.H_ACT(8), .V_ACT(4), .ADDR_W(20), .BASE_ADDR(20'h00100), .FIFO_DEPTH(16)) dut2 (
        .i_clk_25M(clk), .i_rst_n(rst_n), .i_frame_start(frame_start2), .i_pix_req(1'b0),
        .o_rd_req(rd_req2), .o_rd_addr(rd_addr2), .i_rd_ready(rd_ready2), .i_rd_valid(rd_valid2),
        .i_rd_data(rd_data2), .o_VGA_R(vga_r2), .o_VGA_G(vga_g2), .o_VGA_B(vga_b2),
        .o_underflow(underflow2), .o_frame_done(frame_done2));

    function automatic logic [15:0] word_for(input logic [19:0] a);
        int idx;
        idx = int'(a) - 32'h100;
        if (mode == 2) return 16'hAAAA;
        if (mode == 1) begin
            if (idx >= 0 && idx < 6) return colour_tbl[idx].word;
            return 16'h1234;
        end
        return a[15:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: records accepts, returns data in order after lat cycles.
    always @(posedge clk) begin
        if (!rst_n) begin
            dq.delete(); due.delete(); dq2.delete(); due2.delete();
        end else begin
            if (rd_req && rd_ready) begin
                acc_log.push_back(rd_addr);
                dq.push_back(word_for(rd_addr));
                due.push_back(cyc + lat);
            end
            if (rd_req2 && rd_ready2) begin
                acc2 <= acc2 + 1;
                dq2.push_back(rd_addr2[15:0]);
                due2.push_back(cyc + 5);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && due.size() > 0 && due[0] <= cyc) begin
            rd_valid <= 1'b1;
            rd_data  <= dq.pop_front();
            due.delete(0);
        end else begin
            rd_valid <= 1'b0;
        end
        if (rst_n && due2.size() > 0 && due2[0] <= cyc) begin
            rd_valid2 <= 1'b1;
            rd_data2  <= dq2.pop_front();
            due2.delete(0);
        end else begin
            rd_valid2 <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_rgb(input string name, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        check({name, "_rgb"}, {8'h00, vga_r, vga_g, vga_b}, {8'h00, r, g, b});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pop_check(input string name, input pix_vec_t v);
        pix_req = 1'b1;
        tick();
        pix_req = 1'b0;
        check_rgb(name, v.r, v.g, v.b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        // Expected expansions of data = address 0x100..0x107 and of the colour words.
        basic_tbl[0] = '{16'h0100, 8'h00, 8'h20, 8'h00};
        basic_tbl[1] = '{16'h0101, 8'h00, 8'h20, 8'h08};
        basic_tbl[2] = '{16'h0102, 8'h00, 8'h20, 8'h10};
        basic_tbl[3] = '{16'h0103, 8'h00, 8'h20, 8'h18};
        basic_tbl[4] = '{16'h0104, 8'h00, 8'h20, 8'h21};
        basic_tbl[5] = '{16'h0105, 8'h00, 8'h20, 8'h29};
        basic_tbl[6] = '{16'h0106, 8'h00, 8'h20, 8'h31};
        basic_tbl[7] = '{16'h0107, 8'h00, 8'h20, 8'h39};
        colour_tbl[0] = '{16'hF800, 8'hFF, 8'h00, 8'h00};
        colour_tbl[1] = '{16'h07E0, 8'h00, 8'hFF, 8'h00};
        colour_tbl[2] = '{16'h001F, 8'h00, 8'h00, 8'hFF};
        colour_tbl[3] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF};
        colour_tbl[4] = '{16'h0000, 8'h00, 8'h00, 8'h00};
        colour_tbl[5] = '{16'h1234, 8'h10, 8'h45, 8'hA5};

        // Reset state and idle without frame start
        repeat (3) tick();
        check("rst_rd_req", rd_req, 0);
        check("rst_addr", rd_addr, 20'h100);
        check_rgb("rst", 8'h00, 8'h00, 8'h00);
        check("rst_underflow", underflow, 0);
        check("rst_done", frame_done, 0);
        rst_n = 1'b1;
        repeat (4) tick();
        check("idle_rd_req", rd_req, 0);

        // Basic fetch: 8 reads at 0x100..0x107, done after the 8th
        rd_ready = 1'b1;
        base = acc_log.size();
        pulse_fs();
        check("basic_req_first", rd_req, 1);
        check("basic_addr_first", rd_addr, 20'h100);
        for (int k = 0; k < 40 && (acc_log.size() - base) < 7; k++) tick();
        check("basic_seven_accepts", acc_log.size() - base, 7);
        check("basic_done_before_last", frame_done, 0);
        tick();
        check("basic_eight_accepts", acc_log.size() - base, 8);
        check("basic_done", frame_done, 1);
        check("basic_req_after_done", rd_req, 0);
        for (int i = 0; i < 8; i++)
            check($sformatf("basic_addr%0d", i), acc_log[base + i], 20'h100 + 20'(i));
        repeat (10) tick();
        check("basic_no_extra_accepts", acc_log.size() - base, 8);
        for (int i = 0; i < 8; i++) pop_check($sformatf("basic_pix%0d", i), basic_tbl[i]);
        tick();
        check_rgb("basic_hold", basic_tbl[7].r, basic_tbl[7].g, basic_tbl[7].b);

        // Colour expansion, back-to-back requests
        mode = 1;
        pulse_fs();
        repeat (20) tick();
        pix_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 5) pix_req = 1'b0;
            check_rgb($sformatf("colour%0d", i), colour_tbl[i].r, colour_tbl[i].g, colour_tbl[i].b);
        end
        mode = 0;

        // Underflow right after frame start, sticky until next frame start
        pulse_fs();
        pix_req = 1'b1;
        tick();
        pix_req = 1'b0;
        check_rgb("uflow_black", 8'h00, 8'h00, 8'h00);
        check("uflow_set", underflow, 1);
        repeat (15) tick();
        pop_check("uflow_valid_pix", basic_tbl[0]);
        check("uflow_sticky", underflow, 1);
        pulse_fs();
        check("uflow_cleared", underflow, 0);
        check("fs_clears_done", frame_done, 0);

        // Credit limit on the 32-pixel instance with a stalled memory
        frame_start2 = 1'b1;
        tick();
        frame_start2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("stall_req%0d", i), rd_req2, 1);
            check($sformatf("stall_addr%0d", i), rd_addr2, 20'h100);
            tick();
        end
        rd_ready2 = 1'b1;
        repeat (60) tick();
        check("credit_accepts", acc2, 16);
        check("credit_req_low", rd_req2, 0);

        // Frame restart with three stale reads in flight
        lat = 6;
        mode = 2;
        rd_ready = 1'b0;
        pulse_fs();
        rd_ready = 1'b1;
        base = acc_log.size();
        for (int k = 0; k < 40 && (acc_log.size() - base) < 3; k++) tick();
        check("stale_accepts", acc_log.size() - base, 3);
        rd_ready = 1'b0;
        mode = 0;
        pulse_fs();
        rd_ready = 1'b1;
        check("restart_addr", rd_addr, 20'h100);
        check("restart_req", rd_req, 1);
        repeat (30) tick();
        for (int i = 0; i < 8; i++) pop_check($sformatf("restart_pix%0d", i), basic_tbl[i]);
        check("restart_no_uflow", underflow, 0);
        pix_req = 1'b1;
        tick();
        pix_req = 1'b0;
        check_rgb("restart_ninth_black", 8'h00, 8'h00, 8'h00);
        check("restart_ninth_uflow", underflow, 1);

        // Asynchronous reset mid-fetch with the FIFO partly full
        lat = 2;
        pulse_fs();
        pix_req = 1'b1;
        base = acc_log.size();
        tick();
        pix_req = 1'b0;
        for (int k = 0; k < 40 && (acc_log.size() - base) < 4; k++) tick();
        rd_ready = 1'b0;
        check("pre_rst_accepts", acc_log.size() - base, 4);
        repeat (8) tick();
        pop_check("pre_rst_pix", basic_tbl[0]);
        check("pre_rst_req", rd_req, 1);
        check("pre_rst_uflow", underflow, 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_req", rd_req, 0);
        check("async_rst_addr", rd_addr, 20'h100);
        check_rgb("async_rst", 8'h00, 8'h00, 8'h00);
        check("async_rst_uflow", underflow, 0);
        check("async_rst_done", frame_done, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        rd_ready = 1'b1;
        base = acc_log.size();
        repeat (8) tick();
        check("post_rst_idle_req", rd_req, 0);
        check("post_rst_no_accepts", acc_log.size() - base, 0);
        pulse_fs();
        check("post_rst_fs_req", rd_req, 1);
        check("post_rst_fs_addr", rd_addr, 20'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Upstream feeder for the 640x480@60Hz VGA timing stage.
- Prefetches RGB565 pixels from external frame memory (SRAM-style read port) into a small FIFO.
- Delivers one expanded 24-bit RGB pixel per request during the active display region.
- Decouples variable memory read latency from the fixed pixel-clock demand of the VGA stage.

Parameters:
- H_ACT, 640: active pixels per line.
- V_ACT, 480: active lines per frame.
- ADDR_W, 20: memory word address width.
- BASE_ADDR, 0: word address of pixel (0,0); one 16-bit word per pixel, raster order.
- FIFO_DEPTH, 16: prefetch FIFO entries; power of two, at least 4.

Ports:
- i_clk_25M  in  1  pixel clock; all logic on posedge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_frame_start  in  1  one-cycle pulse from the VGA stage at the start of vertical blanking.
- i_pix_req  in  1  VGA stage consumes one active pixel this cycle.
- o_rd_req  out  1  memory read request; one word per asserted cycle.
- o_rd_addr  out  ADDR_W  read word address; valid while o_rd_req is high.
- i_rd_ready  in  1  memory accepts the request this cycle.
- i_rd_valid  in  1  read data return, in request order.
- i_rd_data  in  16  RGB565 read data (R[15:11], G[10:5], B[4:0]).
- o_VGA_R  out  8  red component to the VGA stage.
- o_VGA_G  out  8  green component to the VGA stage.
- o_VGA_B  out  8  blue component to the VGA stage.
- o_underflow  out  1  sticky flag: a request arrived while the FIFO was empty this frame.
- o_frame_done  out  1  high once all H_ACT*V_ACT reads have been issued for the current frame.

Behaviour:
- Reset (asynchronous, i_rst_n low):
  - State IDLE; FIFO empty; issue and pixel counters 0; outstanding = 0; discard = 0.
  - o_rd_req = 0, o_rd_addr = BASE_ADDR.
  - o_VGA_R, o_VGA_G, o_VGA_B = 0.
  - o_underflow = 0, o_frame_done = 0.
- FSM:
  - IDLE: transitions to FETCH on i_frame_start.
  - FETCH: issues reads. When issue_cnt reaches H_ACT*V_ACT, go to DONE and set o_frame_done.
  - DONE: holds until i_frame_start, then goes to FETCH.
  - i_frame_start is accepted in any state and takes priority over all other events in the same cycle.
- Frame start actions:
  - Flush the FIFO; issue_cnt = 0; o_rd_addr = BASE_ADDR.
  - Clear o_underflow and o_frame_done.
  - discard = outstanding, accounting for a return arriving in the same cycle; outstanding = 0.
- Issue rule:
  - o_rd_req = (state == FETCH) and (fifo_count + outstanding < FIFO_DEPTH).
  - The request is accepted when o_rd_req and i_rd_ready are both high.
  - On accept: o_rd_addr increments by 1, issue_cnt increments, outstanding increments.
  - Address and request are registered and held stable until accepted.
- Return rule:
  - On i_rd_valid with discard > 0: drop the word and decrement discard. Data from an old frame must never enter the FIFO.
  - Otherwise: push the word and decrement outstanding.
  - The credit rule guarantees no overflow. A push into a full FIFO is a design error; flag it with an assertion.
- Pop and output:
  - On i_pix_req with the FIFO non-empty: pop and register the expanded pixel to the outputs on the next edge (latency 1 cycle).
  - R8 = {R5, R5[4:2]}; G8 = {G6, G6[5:4]}; B8 = {B5, B5[4:2]}.
  - On i_pix_req with the FIFO empty: outputs become 0 (black) next cycle and o_underflow sets.
  - No i_pix_req: outputs hold their last value.
- Simultaneous push and pop in the same cycle: fifo_count is unchanged and data order is preserved. This also holds when the FIFO is full or when it is empty with a bypassed write.
- Counter widths:
  - issue_cnt is sized for H_ACT*V_ACT.
  - outstanding and discard are sized for FIFO_DEPTH.
  - o_rd_addr wraps modulo 2^ADDR_W with no error.
- Reset asserted mid-frame: everything returns to reset values immediately. Any returns in flight after reset release are not tracked; the system resets memory and the VGA stage together.

Test Plan:
- Basic fetch: H_ACT=4, V_ACT=2, BASE_ADDR=0x100, memory returns 2 cycles after accept with data = address. Pulse frame start.
  - Expect exactly 8 reads at 0x100..0x107.
  - Expect o_frame_done=1 after the 8th accept.
  - Expect 8 requests to yield pixels in order 0x100..0x107, each expanded.
- Colour expansion: return 0xF800, 0x07E0, 0x001F, 0xFFFF, 0x0000.
  - Expect RGB (FF,00,00), (00,FF,00), (00,00,FF), (FF,FF,FF), (00,00,00), each 1 cycle after its request.
- Backpressure and credit: hold i_rd_ready=0 for 20 cycles, then 1; latency 5; no pixel requests.
  - Expect o_rd_req stable with unchanged address while stalled.
  - Expect at most FIFO_DEPTH=16 accepts total; o_rd_req drops when fifo_count+outstanding=16.
- Underflow: pixel request on the cycle right after frame start, before any return.
  - Expect RGB=0 and o_underflow=1.
  - Expect o_underflow to stay 1 through subsequent valid pixels and clear on the next frame start.
- Frame restart with data in flight: latency 6, frame start after 3 accepts, then 3 stale returns (0xAAAA).
  - Expect all 3 dropped.
  - Expect the FIFO's first entry to be the new frame's BASE_ADDR word.
  - Expect o_rd_addr to restart at BASE_ADDR.
- Async reset mid-fetch: assert i_rst_n=0 between clock edges with the FIFO half full.
  - Expect o_rd_req, RGB, o_underflow and o_frame_done all 0 immediately, without waiting for a clock edge.
  - Expect the block to stay idle after release until a frame start.
